// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Fetch/data arbiter for one single-port memory, with a
//               starvation guard that lets fetch win.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_gnt,
   output logic                o_if_valid,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_d_req,
   input  logic                i_d_we,
   input  logic [ADDR_W-1:0]   i_d_addr,
   input  logic [DATA_W-1:0]   i_d_wdata,
   input  logic [DATA_W/8-1:0] i_d_be,
   output logic                o_d_gnt,
   output logic                o_d_valid,
   output logic [DATA_W-1:0]   o_d_rdata,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_be,
   input  logic                i_mem_ready,
   input  logic [DATA_W-1:0]   i_mem_rdata
);

   localparam int                c_BE_W       = DATA_W / 8;
   localparam int                c_SC_W       = $clog2(STARVE_MAX + 1);
   localparam logic [c_SC_W-1:0] c_STARVE_MAX = c_SC_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                w_if_gnt;
   logic                w_d_gnt;
   logic [c_SC_W-1:0]   r_starve;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic [c_BE_W-1:0]   r_be;
   logic                r_if_valid;
   logic                r_d_valid;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_d_rdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Data normally wins; fetch wins once data has been favoured STARVE_MAX times.
   always_comb begin
      w_next   = r_state;
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_if_req && (!i_d_req || (r_starve == c_STARVE_MAX))) begin
               w_if_gnt = 1'b1;
               w_next   = BUSY_I;
            end else if (i_d_req) begin
               w_d_gnt  = 1'b1;
               w_next   = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (i_mem_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_starve   <= '0;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         if (w_if_gnt) begin
            r_addr   <= i_if_addr;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_be     <= '1;
            r_starve <= '0;
         end else if (w_d_gnt) begin
            r_addr  <= i_d_addr;
            r_we    <= i_d_we;
            r_wdata <= i_d_wdata;
            r_be    <= i_d_be;
            if (i_if_req && (r_starve != c_STARVE_MAX)) begin
               r_starve <= r_starve + 1'b1;
            end
         end
         if ((r_state == BUSY_I) && i_mem_ready) begin
            r_if_valid <= 1'b1;
            r_if_rdata <= i_mem_rdata;
         end
         if ((r_state == BUSY_D) && i_mem_ready) begin
            r_d_valid <= 1'b1;
            r_d_rdata <= i_mem_rdata;
         end
      end
   end

   assign o_if_gnt    = w_if_gnt;
   assign o_d_gnt     = w_d_gnt;
   assign o_if_valid  = r_if_valid;
   assign o_if_rdata  = r_if_rdata;
   assign o_d_valid   = r_d_valid;
   assign o_d_rdata   = r_d_rdata;
   assign o_mem_req   = (r_state != IDLE);
   assign o_mem_we    = r_we && (r_state == BUSY_D);
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_mem_be    = r_be;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  ADDR_W  32  address width
  DATA_W  32  data width
  STARVE_MAX  4  consecutive data grants, while fetch is waiting, before fetch is forced to win
REQ-002 Ports, one per line (name  direction  width  meaning):
  i_clk  in  1  single clock; all state changes on the rising edge
  i_rst_n  in  1  asynchronous, active-low reset
  i_if_req  in  1  instruction-fetch request; held until o_if_gnt
  i_if_addr  in  ADDR_W  fetch address
  o_if_gnt  out  1  fetch request accepted this cycle
  o_if_valid  out  1  one-cycle pulse: o_if_rdata valid
  o_if_rdata  out  DATA_W  fetched word
  i_d_req  in  1  load/store request; held until o_d_gnt
  i_d_we  in  1  1 = store, 0 = load
  i_d_addr  in  ADDR_W  data address
  i_d_wdata  in  DATA_W  store data
  i_d_be  in  DATA_W/8  byte enables
  o_d_gnt  out  1  data request accepted this cycle
  o_d_valid  out  1  one-cycle pulse: load data valid or store complete
  o_d_rdata  out  DATA_W  load data
  o_mem_req  out  1  request to the single-port memory
  o_mem_we  out  1  memory write enable
  o_mem_addr  out  ADDR_W  memory address
  o_mem_wdata  out  DATA_W  memory write data
  o_mem_be  out  DATA_W/8  memory byte enables
  i_mem_ready  in  1  memory completes the current access this cycle
  i_mem_rdata  in  DATA_W  memory read data; valid when i_mem_ready=1

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY_I, BUSY_D.
REQ-004 Arbitration in IDLE:
  - only i_d_req = 1 -> data wins
  - only i_if_req = 1 -> fetch wins
  - both = 1 -> data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins
REQ-005 Grant output: o_if_gnt / o_d_gnt SHALL be combinational, high only in the IDLE cycle that accepts that requester, and never both high in the same cycle.
REQ-006 On a grant, the block SHALL register address, we, wdata and be (fetch: we=0, be=all ones) and move to BUSY_I or BUSY_D on the next edge.
REQ-007 In BUSY_x:
  - o_mem_req = 1; o_mem_* are driven from the registered values and stay stable
  - the state is held until i_mem_ready = 1
REQ-008 On a BUSY_x cycle with i_mem_ready = 1, the next edge SHALL:
  - capture i_mem_rdata into o_x_rdata
  - pulse o_x_valid for one cycle
  - return the FSM to IDLE
REQ-009 Latency: grant at cycle N, o_mem_req at N+1, earliest valid at N+2; each access adds one cycle per i_mem_ready = 0 wait cycle.
REQ-010 A new grant SHALL be possible in the same cycle that o_x_valid is high (FSM is in IDLE); back-to-back throughput SHALL be one access per 2 cycles minimum.
REQ-011 i_mem_ready SHALL be ignored in IDLE; request inputs SHALL be ignored in BUSY_x (no grant).
REQ-012 starve_cnt, width clog2(STARVE_MAX+1):
  - increments, saturating at STARVE_MAX, on each data grant while i_if_req = 1
  - clears on each fetch grant
  - otherwise holds
REQ-013 A store SHALL also produce the o_d_valid pulse; o_d_rdata on a store completion SHALL be the captured i_mem_rdata value and has no meaning.
REQ-014 o_if_rdata / o_d_rdata SHALL hold their last value between valid pulses.

Reset
REQ-015 i_rst_n = 0 SHALL immediately, without waiting for a clock edge, force:
  - FSM to IDLE, starve_cnt = 0
  - o_mem_req, o_mem_we, o_if_valid, o_d_valid = 0
  - o_mem_addr, o_mem_wdata, o_mem_be, o_if_rdata, o_d_rdata = 0
REQ-016 Reset asserted during BUSY_x SHALL abandon the access with no valid pulse; the first grant is possible in the first cycle after release.

Verification
REQ-017 The bench SHALL cover these scenarios:
  - Single fetch: if_req, addr=0x10, ready next cycle with rdata=0xDEADBEEF -> gnt at N, mem_req/addr=0x10 at N+1, o_if_valid with 0xDEADBEEF at N+2.
  - Store: d_req, we=1, addr=0x20, wdata=0x12345678, be=0x3, ready delayed 3 cycles -> o_mem_* stable for 4 cycles, o_mem_we=1, o_d_valid one cycle after ready.
  - Contention: both requests held continuously -> grants D,D,D,D,I,D,D,D,D,I...; o_if_gnt and o_d_gnt never both high.
  - Reset mid-access: rst_n low for 3 ns during BUSY_D -> o_mem_req = 0 before the next edge, no o_d_valid, starve_cnt = 0, new request granted the cycle after release.
  - Spurious i_mem_ready in IDLE -> no valid pulse and no state change; requests asserted during BUSY -> no grant until IDLE.
